// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing helpers for the convolution MAC stage
package conv_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

  function automatic int positions(input int extent, input int k, input int s, input int p);
    return (extent - k + 2 * p) / s + 1;
  endfunction

  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Index widths never collapse to zero so single-entry configurations still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ACC_WIDTH = acc_width(8, 9);
  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/conv_mac_unit.sv
// rtl/conv_mac_unit.sv - registered signed multiply-accumulate with clear and enable
module conv_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  acc_next
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod     = a * b;
  assign acc_next = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - serial dot-product over im2col columns, streamed in raster order
// Optional CONV_MAC_RELU_EN clamps negative results to zero.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH          = 20,
  parameter int IMAGE_HEIGHT         = 20,
  parameter int KERNEL_SIZE          = 3,
  parameter int STRIDE               = 1,
  parameter int PADDING              = 0,
  parameter int DATA_WIDTH           = 8,
  parameter int HORIZONTAL_POSITIONS = positions(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING),
  parameter int VERTICAL_POSITIONS   = positions(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING),
  parameter int OUTPUT_WIDTH         = HORIZONTAL_POSITIONS * VERTICAL_POSITIONS,
  parameter int OUTPUT_HEIGTH        = KERNEL_SIZE * KERNEL_SIZE,
  parameter int ACC_WIDTH            = acc_width(DATA_WIDTH, OUTPUT_HEIGTH)
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0]       kernel,
  input  logic [0:OUTPUT_HEIGTH-1][0:OUTPUT_WIDTH-1][DATA_WIDTH-1:0]    col_matrix,
  input  logic                                                          start,
  output logic                                                          busy,
  output logic                                                          out_valid,
  input  logic                                                          out_ready,
  output logic signed [ACC_WIDTH-1:0]                                   out_data,
  output logic [idx_width(OUTPUT_WIDTH)-1:0]                            out_index,
  output logic                                                          done
);

  localparam int TAP_W = idx_width(OUTPUT_HEIGTH);
  localparam int IDX_W = idx_width(OUTPUT_WIDTH);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(OUTPUT_HEIGTH - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(OUTPUT_WIDTH - 1);

  state_t                          state;
  logic [TAP_W-1:0]                tap;
  logic [IDX_W-1:0]                col;
  logic [0:OUTPUT_HEIGTH-1][DATA_WIDTH-1:0] kernel_flat;
  logic signed [DATA_WIDTH-1:0]    mac_a;
  logic signed [DATA_WIDTH-1:0]    mac_b;
  logic signed [ACC_WIDTH-1:0]     mac_acc;
  logic signed [ACC_WIDTH-1:0]     mac_sum;
  logic signed [ACC_WIDTH-1:0]     result;

  // Row-major flattening makes kernel_flat[tap] equal kernel[tap/K][tap%K].
  assign kernel_flat = kernel;
  assign mac_a       = kernel_flat[tap];
  assign mac_b       = col_matrix[tap][col];

  conv_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != ACCUM),
    .en       (state == ACCUM),
    .a        (mac_a),
    .b        (mac_b),
    .acc      (mac_acc),
    .acc_next (mac_sum)
  );

  always_comb begin
    result = mac_sum;
`ifdef CONV_MAC_RELU_EN
    if (mac_sum[ACC_WIDTH-1]) result = '0;
`else
    result = mac_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
            col   <= '0;
            tap   <= '0;
          end
        end
        ACCUM: begin
          tap <= tap + 1'b1;
          if (tap == LAST_TAP) begin
            tap       <= '0;
            out_data  <= result;
            out_index <= col;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (col == LAST_COL) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              col   <= col + 1'b1;
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Sequential dot-product stage directly downstream of im2col_2d.
- Takes the flattened kernel and the combinational im2col column matrix, and computes one convolution output per column by K*K serial multiply-accumulates.
- Streams results out with a valid/ready handshake in raster order (column index 0 .. OUTPUT_WIDTH-1).
- Feeds the output feature-map writer.

Parameters:
- IMAGE_WIDTH, 20, input image width in pixels
- IMAGE_HEIGHT, 20, input image height in pixels
- KERNEL_SIZE, 3, square kernel edge
- STRIDE, 1, window step (used only to derive position counts)
- PADDING, 0, border padding (used only to derive position counts)
- DATA_WIDTH, 8, signed two's-complement pixel/weight width
- HORIZONTAL_POSITIONS, (IMAGE_WIDTH-KERNEL_SIZE+2*PADDING)/STRIDE+1, output columns per row
- VERTICAL_POSITIONS, (IMAGE_HEIGHT-KERNEL_SIZE+2*PADDING)/STRIDE+1, output rows
- OUTPUT_WIDTH, HORIZONTAL_POSITIONS*VERTICAL_POSITIONS, im2col column count
- OUTPUT_HEIGTH, KERNEL_SIZE*KERNEL_SIZE, im2col row count (taps)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(OUTPUT_HEIGTH), accumulator and result width

Ports:
- clk  in  1  single clock; all state rises on posedge
- rst_n  in  1  asynchronous, active-low reset
- kernel  in  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0]  weights; must be held stable while busy
- col_matrix  in  [0:OUTPUT_HEIGTH-1][0:OUTPUT_WIDTH-1][DATA_WIDTH-1:0]  im2col output; must be held stable while busy
- start  in  1  single-cycle request to begin a frame
- busy  out  1  high from start acceptance until done
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_WIDTH  signed convolution result
- out_index  out  $clog2(OUTPUT_WIDTH)  column index of out_data
- done  out  1  one-cycle pulse after the last result transfer

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE. busy, out_valid, done, out_data and out_index are all 0. Counters and accumulator are cleared.
- IDLE:
  - start=1 -> ACCUM. Set busy=1, col=0, tap=0, acc=0.
  - start is ignored in every other state.
- ACCUM:
  - Each cycle: acc += signed(kernel[tap/K][tap%K]) * signed(col_matrix[tap][col]), sign-extended to ACC_WIDTH.
  - tap increments each cycle. After tap==OUTPUT_HEIGTH-1 the final sum latches into out_data, out_index=col, and the FSM enters EMIT.
  - Exactly OUTPUT_HEIGTH cycles per column.
- EMIT:
  - out_valid=1. out_data and out_index hold stable until out_ready=1.
  - On handshake with col<OUTPUT_WIDTH-1: out_valid drops next cycle, col++, tap=0, acc=0, back to ACCUM.
  - On handshake with col==OUTPUT_WIDTH-1: -> DONE.
  - out_ready asserted before out_valid has no effect.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- Timing:
  - With out_ready tied high, throughput is OUTPUT_HEIGTH+1 cycles per column.
  - Frame latency from start to done = OUTPUT_WIDTH*(OUTPUT_HEIGTH+1)+1 cycles.
  - A start in the DONE cycle is ignored. A start on the cycle after done is accepted.
- Arithmetic: products are full 2*DATA_WIDTH signed and never saturate. ACC_WIDTH guarantees no overflow.
- Reset mid-frame: immediate abort to IDLE with all outputs 0. No done pulse is issued.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- When defined: the value latched into out_data at the end of ACCUM is clamped to 0 if negative. Timing is unchanged.
- When undefined: raw signed sum is output.

Decomposition:
- conv_pkg holds:
  - position-count derivation functions and ACC_WIDTH function
  - state enum typedef (IDLE, ACCUM, EMIT, DONE)
  - signed acc_t typedef
- Natural sub-module: conv_mac_unit. It is a registered signed multiply-accumulate with clear and enable. The FSM and counters stay in conv_mac_engine.

Test Plan:
All scenarios use IMAGE 4x4, KERNEL_SIZE=2, DATA_WIDTH=8 (9 columns, 4 taps), unless stated otherwise.
- Identity check: image = 0..15 raster, kernel all 1, out_ready=1 -> outputs 10,14,18,26,30,34,42,46,50 at indices 0..8; done 46 cycles after start.
- Signed extremes: all pixels -128, all weights -128 -> every out_data=65536; all weights 127 -> every out_data=-65024.
- Backpressure: out_ready low for 5 cycles at index 3 -> out_valid, out_data and out_index held; no results lost or duplicated; all 9 results delivered in order.
- Reset mid-frame: rst_n pulsed low during ACCUM of index 4 -> all outputs 0 immediately, no done; a new start then gives a full, correct 9-result frame.
- Ignored start: start pulses while busy and in the DONE cycle -> no effect; start one cycle after done -> new frame begins.
- CONV_MAC_RELU_EN: kernel {1,-1,-1,-1}, image all 5 -> every out_data=0 with the macro defined; -10 without it.
